// File: rtl/sw_debounce.sv
// sw_debounce
//
// Debounces a bank of independent switch/button inputs. Each channel is
// first brought into the clk domain through a two-flop synchronizer. A new
// level is accepted only after it has been stable for DB_CYCLES consecutive
// cycles. On the edge where a debounced level changes, the matching
// rise/fall pulse and the shared change pulse go high for one cycle.
//
// Parameters:
//   WIDTH      number of independent channels
//   DB_CYCLES  stable cycles needed to accept a new level (2 .. 2^20-1)
//
// Ports:
//   clk     rising-edge clock; all state updates happen on this edge
//   rst     synchronous, active-high reset
//   sw_i    raw asynchronous switch levels taken straight from the pins
//   sw_o    registered debounced levels
//   rise_o  one-cycle pulse per bit when sw_o goes 0->1
//   fall_o  one-cycle pulse per bit when sw_o goes 1->0
//   chg_o   one-cycle pulse when any rise_o/fall_o bit is high
module sw_debounce #(
    parameter int WIDTH     = 16,
    parameter int DB_CYCLES = 50000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_i,
    output logic [WIDTH-1:0] sw_o,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o,
    output logic             chg_o
);

    localparam int            CW   = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] flip;

    // A channel flips on the edge where it is still mismatched and its
    // counter already holds DB_CYCLES-1. That value is therefore always
    // consumed here, so the counter can never wrap.
    always_comb begin
        flip = '0;
        for (int i = 0; i < WIDTH; i++) begin
            flip[i] = (s2[i] != sw_o[i]) && (cnt[i] == LAST);
        end
    end

    // Synchronizer, per-channel stability counters, and the registered
    // level and pulse outputs. Reset overrides every other update.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1     <= '0;
            s2     <= '0;
            sw_o   <= '0;
            rise_o <= '0;
            fall_o <= '0;
            chg_o  <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1     <= sw_i;
            s2     <= s1;
            sw_o   <= sw_o ^ flip;
            rise_o <= flip & ~sw_o;
            fall_o <= flip & sw_o;
            chg_o  <= |flip;
            for (int i = 0; i < WIDTH; i++) begin
                // A mismatch that ends early (a bounce) drops the count
                // back to zero. The count also clears on the accepting edge.
                if ((s2[i] == sw_o[i]) || flip[i]) begin
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sw_debounce.sv
// tb_sw_debounce
//
// Drives sw_debounce (WIDTH=16, DB_CYCLES=4) with directed scenarios and then
// with random toggling and occasional resets. A reference model compares the
// outputs on every clock. It flips a debounced bit only when the synchronized
// input has disagreed with it on each of the last DB_CYCLES non-reset edges.
// The directed scenarios also check hand-computed literal values.
//
// Edge numbering: inputs change just after an edge. The next rising edge,
// which first samples the new value, is edge 1. A clean change therefore
// shows up on sw_o at edge DB_CYCLES+2 = 6.
module tb_sw_debounce;

    localparam int W  = 16;
    localparam int DB = 4;

    logic         clk;
    logic         rst;
    logic [W-1:0] sw_i;
    logic [W-1:0] sw_o;
    logic [W-1:0] rise_o;
    logic [W-1:0] fall_o;
    logic         chg_o;

    int checks = 0;
    int errors = 0;

    sw_debounce #(.WIDTH(W), .DB_CYCLES(DB)) dut (
        .clk    (clk),
        .rst    (rst),
        .sw_i   (sw_i),
        .sw_o   (sw_o),
        .rise_o (rise_o),
        .fall_o (fall_o),
        .chg_o  (chg_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one value against its expectation and counts the result.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic [W-1:0] sw, input logic r);
        sw_i = sw;
        rst  = r;
    endtask

    // Waits for the next rising edge, then settles past the model compare.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic         rst;
        logic [W-1:0] raw;
    } edge_t;

    edge_t        hist[$];
    logic [W-1:0] exp_sw   = '0;
    logic [W-1:0] exp_rise = '0;
    logic [W-1:0] exp_fall = '0;
    logic         exp_chg  = 1'b0;
    bit           model_ready = 0;

    // Edge k back in history. Edges before the first one count as reset edges.
    function automatic edge_t hist_at(input int k);
        edge_t e;
        e.rst = 1'b1;
        e.raw = '0;
        if (k < hist.size()) e = hist[k];
        return e;
    endfunction

    // Synchronized level seen k edges ago. It is the raw input from two
    // edges earlier, or zero if either of the two edges in between was a reset.
    function automatic logic [W-1:0] synced_at(input int k);
        edge_t a;
        edge_t b;
        a = hist_at(k + 1);
        b = hist_at(k + 2);
        if (a.rst || b.rst) return '0;
        return b.raw;
    endfunction

    always @(posedge clk) begin
        edge_t        e;
        edge_t        h;
        logic [W-1:0] old;
        logic [W-1:0] flip;
        logic [W-1:0] s;
        bit           stable;
        e.rst = rst;
        e.raw = sw_i;
        hist.push_front(e);
        if (hist.size() > DB + 4) void'(hist.pop_back());
        old = exp_sw;
        if (rst) begin
            exp_sw      = '0;
            exp_rise    = '0;
            exp_fall    = '0;
            exp_chg     = 1'b0;
            model_ready = 1;
        end else begin
            flip = '0;
            for (int b = 0; b < W; b++) begin
                stable = 1;
                for (int k = 0; k < DB; k++) begin
                    h = hist_at(k);
                    s = synced_at(k);
                    if (h.rst || (s[b] == old[b])) stable = 0;
                end
                flip[b] = stable;
            end
            exp_sw   = old ^ flip;
            exp_rise = flip & ~old;
            exp_fall = flip & old;
            exp_chg  = |flip;
        end
        #1;
        if (model_ready) begin
            checkOutput("model sw_o",   32'(sw_o),   32'(exp_sw));
            checkOutput("model rise_o", 32'(rise_o), 32'(exp_rise));
            checkOutput("model fall_o", 32'(fall_o), 32'(exp_fall));
            checkOutput("model chg_o",  32'(chg_o),  32'(exp_chg));
        end
    end

    // ---------------- stimulus ----------------
    logic [W-1:0] cur;

    initial begin
        applyStimulus(16'hFFFF, 1'b1);
        tick(3);
        checkOutput("reset sw_o", 32'(sw_o), 32'h0);
        checkOutput("reset chg_o", 32'(chg_o), 32'h0);

        // Input held high across reset release
        applyStimulus(16'hFFFF, 1'b0);
        tick(5);
        checkOutput("post-reset edge5 sw_o", 32'(sw_o), 32'h0);
        tick(1);
        checkOutput("post-reset edge6 sw_o", 32'(sw_o), 32'hFFFF);
        checkOutput("post-reset edge6 rise_o", 32'(rise_o), 32'hFFFF);
        checkOutput("post-reset edge6 chg_o", 32'(chg_o), 32'h1);
        tick(1);
        checkOutput("post-reset edge7 rise_o", 32'(rise_o), 32'h0);
        checkOutput("post-reset edge7 chg_o", 32'(chg_o), 32'h0);

        // Return to a clean all-zero state
        applyStimulus(16'h0000, 1'b1);
        tick(3);
        applyStimulus(16'h0000, 1'b0);
        tick(3);

        // Clean rising edge on bit 3
        applyStimulus(16'h0008, 1'b0);
        tick(5);
        checkOutput("clean edge5 sw_o", 32'(sw_o), 32'h0);
        tick(1);
        checkOutput("clean edge6 sw_o", 32'(sw_o), 32'h0008);
        checkOutput("clean edge6 rise_o", 32'(rise_o), 32'h0008);
        tick(1);
        checkOutput("clean edge7 rise_o", 32'(rise_o), 32'h0);

        // Bounce on bit 0: 1,0,1,0 every two cycles, then hold 1
        for (int i = 0; i < 4; i++) begin
            applyStimulus(16'h0008 | 16'((i % 2 == 0) ? 1 : 0), 1'b0);
            for (int j = 0; j < 2; j++) begin
                tick(1);
                checkOutput("bounce no rise0", 32'(rise_o[0]), 32'h0);
                checkOutput("bounce no fall0", 32'(fall_o[0]), 32'h0);
            end
        end
        applyStimulus(16'h0009, 1'b0);
        for (int j = 0; j < 5; j++) begin
            tick(1);
            checkOutput("bounce early sw_o0", 32'(sw_o[0]), 32'h0);
        end
        tick(1);
        checkOutput("bounce edge6 sw_o", 32'(sw_o), 32'h0009);
        checkOutput("bounce edge6 rise_o", 32'(rise_o), 32'h0001);

        // Simultaneous fall of 00F0 and rise of 0F00
        applyStimulus(16'h00F0, 1'b0);
        tick(10);
        checkOutput("simul setup sw_o", 32'(sw_o), 32'h00F0);
        applyStimulus(16'h0F00, 1'b0);
        tick(5);
        checkOutput("simul edge5 chg_o", 32'(chg_o), 32'h0);
        tick(1);
        checkOutput("simul edge6 fall_o", 32'(fall_o), 32'h00F0);
        checkOutput("simul edge6 rise_o", 32'(rise_o), 32'h0F00);
        checkOutput("simul edge6 chg_o", 32'(chg_o), 32'h1);
        tick(1);
        checkOutput("simul edge7 chg_o", 32'(chg_o), 32'h0);

        // Glitch on bit 7 lasting three cycles
        applyStimulus(16'h0F80, 1'b0);
        tick(3);
        applyStimulus(16'h0F00, 1'b0);
        for (int j = 0; j < 10; j++) begin
            tick(1);
            checkOutput("glitch rise7", 32'(rise_o[7]), 32'h0);
            checkOutput("glitch chg_o", 32'(chg_o), 32'h0);
        end
        checkOutput("glitch sw_o", 32'(sw_o), 32'h0F00);

        // Reset while a change on bit 5 has counted to 3
        applyStimulus(16'h0F20, 1'b0);
        tick(5);
        applyStimulus(16'h0F20, 1'b1);
        tick(2);
        checkOutput("midreset sw_o", 32'(sw_o), 32'h0);
        applyStimulus(16'h0F20, 1'b0);
        for (int j = 0; j < 5; j++) begin
            tick(1);
            checkOutput("midreset no early chg", 32'(chg_o), 32'h0);
        end
        tick(1);
        checkOutput("midreset edge6 sw_o", 32'(sw_o), 32'h0F20);
        checkOutput("midreset edge6 rise_o", 32'(rise_o), 32'h0F20);

        // Random toggling with occasional resets, checked by the model
        cur = 16'h0F20;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(3) == 0) cur = cur ^ (16'h1 << $urandom_range(W - 1));
            applyStimulus(cur, ($urandom_range(299) == 0));
            tick(1);
        end
        applyStimulus(cur, 1'b0);
        tick(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
